// File: rtl/decode_issue_stage.sv
// Decode-to-execute issue register with load-use interlock, execute back-pressure and flush.
// Optional STALL_CNT_EN adds a free-running bubble/hold cycle counter on stall_cnt.
module decode_issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [31:0] id_pc,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_wreg,
  input  logic        id_reg_write,
  input  logic        id_mem_read,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_rdata1,
  output logic [31:0] ex_rdata2,
  output logic [31:0] ex_imm,
  output logic [4:0]  ex_wreg,
  output logic        ex_reg_write,
  output logic        ex_mem_read
`ifdef STALL_CNT_EN
  ,
  output logic [31:0] stall_cnt
`endif
);

  typedef enum logic {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_ex_valid;
  logic        r_ex_reg_write;
  logic        r_ex_mem_read;
  logic [31:0] r_ex_pc;
  logic [31:0] r_ex_rdata1;
  logic [31:0] r_ex_rdata2;
  logic [31:0] r_ex_imm;
  logic [4:0]  r_ex_wreg;

  logic        w_ex_valid_nxt;
  logic        w_ex_reg_write_nxt;
  logic        w_ex_mem_read_nxt;
  logic        w_load;
  logic        w_wreg_match;
  logic        w_hazard;
  logic        w_hold;

  // Load-use interlock: a load in EX whose destination is read by ID; $0 never matches.
  always_comb begin
    w_wreg_match = (r_ex_wreg == id_rs) | (r_ex_wreg == id_rt);
    w_hazard     = r_ex_valid & r_ex_mem_read & (r_ex_wreg != '0) & id_valid & w_wreg_match;
    w_hold       = r_ex_valid & ~ex_ready;
    id_ready     = flush | (~w_hold & ~w_hazard);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority flush > hold > hazard > load > idle; control flags are only ever
  // nonzero alongside ex_valid.
  always_comb begin
    w_state_nxt        = RUN;
    w_ex_valid_nxt     = r_ex_valid;
    w_ex_reg_write_nxt = r_ex_reg_write;
    w_ex_mem_read_nxt  = r_ex_mem_read;
    w_load             = 1'b0;
    if (flush) begin
      w_ex_valid_nxt     = 1'b0;
      w_ex_reg_write_nxt = 1'b0;
      w_ex_mem_read_nxt  = 1'b0;
    end else if (w_hold) begin
      w_state_nxt = r_state;
    end else if (w_hazard) begin
      w_state_nxt        = BUBBLE;
      w_ex_valid_nxt     = 1'b0;
      w_ex_reg_write_nxt = 1'b0;
      w_ex_mem_read_nxt  = 1'b0;
    end else if (id_valid) begin
      w_load             = 1'b1;
      w_ex_valid_nxt     = 1'b1;
      w_ex_reg_write_nxt = id_reg_write;
      w_ex_mem_read_nxt  = id_mem_read;
    end else begin
      w_ex_valid_nxt     = 1'b0;
      w_ex_reg_write_nxt = 1'b0;
      w_ex_mem_read_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_valid     <= 1'b0;
      r_ex_reg_write <= 1'b0;
      r_ex_mem_read  <= 1'b0;
    end else begin
      r_ex_valid     <= w_ex_valid_nxt;
      r_ex_reg_write <= w_ex_reg_write_nxt;
      r_ex_mem_read  <= w_ex_mem_read_nxt;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ex_pc     <= '0;
      r_ex_rdata1 <= '0;
      r_ex_rdata2 <= '0;
      r_ex_imm    <= '0;
      r_ex_wreg   <= '0;
    end else if (w_load) begin
      r_ex_pc     <= id_pc;
      r_ex_rdata1 <= id_rdata1;
      r_ex_rdata2 <= id_rdata2;
      r_ex_imm    <= id_imm;
      r_ex_wreg   <= id_wreg;
    end
  end

  assign ex_valid     = r_ex_valid;
  assign ex_reg_write = r_ex_reg_write;
  assign ex_mem_read  = r_ex_mem_read;
  assign ex_pc        = r_ex_pc;
  assign ex_rdata1    = r_ex_rdata1;
  assign ex_rdata2    = r_ex_rdata2;
  assign ex_imm       = r_ex_imm;
  assign ex_wreg      = r_ex_wreg;

`ifdef STALL_CNT_EN
  logic        w_stall_evt;
  logic [31:0] r_stall_cnt;

  // Flush overrides both stall sources, so a flushed edge is never counted.
  assign w_stall_evt = ~flush & (w_hold | w_hazard);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall_evt) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed bench for decode_issue_stage: issued instructions are scoreboarded and
// compared when the execute stage consumes them; interlock/flush/reset checked inline.
module tb_decode_issue_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [31:0] id_rdata1;
  logic [31:0] id_rdata2;
  logic [31:0] id_imm;
  logic [4:0]  id_wreg;
  logic        id_reg_write;
  logic        id_mem_read;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [4:0]  ex_wreg;
  logic        ex_reg_write;
  logic        ex_mem_read;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  decode_issue_stage dut (
    .clock        (clock),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_ready     (id_ready),
    .id_pc        (id_pc),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rdata1    (id_rdata1),
    .id_rdata2    (id_rdata2),
    .id_imm       (id_imm),
    .id_wreg      (id_wreg),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .ex_ready     (ex_ready),
    .ex_valid     (ex_valid),
    .ex_pc        (ex_pc),
    .ex_rdata1    (ex_rdata1),
    .ex_rdata2    (ex_rdata2),
    .ex_imm       (ex_imm),
    .ex_wreg      (ex_wreg),
    .ex_reg_write (ex_reg_write),
    .ex_mem_read  (ex_mem_read)
`ifdef STALL_CNT_EN
    ,
    .stall_cnt    (stall_cnt)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] imm;
    logic [4:0]  wreg;
    logic        rw;
    logic        mr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   exp_stall = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  task automatic chk_stall(input string tag);
`ifdef STALL_CNT_EN
    chk(tag, stall_cnt, exp_stall);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] imm, input logic [4:0] wr, input logic rw,
                       input logic mr, input bit push);
    exp_t e;
    id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt;
    id_rdata1 = r1; id_rdata2 = r2; id_imm = imm; id_wreg = wr;
    id_reg_write = rw; id_mem_read = mr;
    if (push) begin
      e.pc = pc; e.r1 = r1; e.r2 = r2; e.imm = imm; e.wreg = wr; e.rw = rw; e.mr = mr;
      exp_q.push_back(e);
    end
  endtask

  // Check id_ready mid-cycle, then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic exp_rdy);
    @(negedge clock);
    chk(tag, id_ready, exp_rdy);
    @(posedge clock);
    #1;
  endtask

  // Execute stage consumes the slot on an edge where ex_valid & ex_ready.
  always @(negedge clock) begin
    if (reset === 1'b1 && ex_valid === 1'b1 && ex_ready === 1'b1) begin
      chk("mon_expected_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("mon_pc", ex_pc, mon_e.pc);
        chk("mon_rdata1", ex_rdata1, mon_e.r1);
        chk("mon_rdata2", ex_rdata2, mon_e.r2);
        chk("mon_imm", ex_imm, mon_e.imm);
        chk("mon_wreg", ex_wreg, mon_e.wreg);
        chk("mon_reg_write", ex_reg_write, mon_e.rw);
        chk("mon_mem_read", ex_mem_read, mon_e.mr);
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    chk("rst_ex_valid", ex_valid, 1'b0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    chk("rst_ex_wreg", ex_wreg, 5'd0);
    chk("rst_ex_rw", ex_reg_write, 1'b0);
    chk("rst_ex_mr", ex_mem_read, 1'b0);
    chk_stall("rst_stall");
    reset = 1'b1;

    // Pass-through on the first edge after reset release.
    drive(1'b1, 32'h0040_0000, 5'd1, 5'd2, 32'h11, 32'h22, 32'h4, 5'd8, 1'b1, 1'b0, 1'b1);
    cyc("A_ready", 1'b1);
    chk("A_ex_valid", ex_valid, 1'b1);
    chk("A_ex_pc", ex_pc, 32'h0040_0000);
    chk("A_ex_rdata1", ex_rdata1, 32'h11);
    chk("A_ex_wreg", ex_wreg, 5'd8);

    // Load to r9, then load-use on rs.
    drive(1'b1, 32'h404, 5'd3, 5'd4, 32'hB1, 32'hB2, 32'h10, 5'd9, 1'b1, 1'b1, 1'b1);
    cyc("B_ready", 1'b1);
    chk("B_ex_mem_read", ex_mem_read, 1'b1);
    drive(1'b1, 32'h408, 5'd9, 5'd5, 32'hC1, 32'hC2, 32'h20, 5'd10, 1'b1, 1'b0, 1'b1);
    cyc("C_hazard_ready", 1'b0);
    exp_stall++;
    chk("C_bubble_valid", ex_valid, 1'b0);
    chk("C_bubble_rw", ex_reg_write, 1'b0);
    chk("C_bubble_mr", ex_mem_read, 1'b0);
    cyc("C_issue_ready", 1'b1);
    chk("C_ex_valid", ex_valid, 1'b1);
    chk("C_ex_pc", ex_pc, 32'h408);
    chk_stall("C_stall");

    // Load to $0 followed by a reader of $0: no stall.
    drive(1'b1, 32'h40C, 5'd1, 5'd2, 32'hD1, 32'hD2, 32'h0, 5'd0, 1'b1, 1'b1, 1'b1);
    cyc("D_ready", 1'b1);
    drive(1'b1, 32'h410, 5'd0, 5'd0, 32'hE1, 32'hE2, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1);
    cyc("E_r0_ready", 1'b1);
    chk("E_ex_pc", ex_pc, 32'h410);
    // Non-load to r9 followed by a reader of r9: no stall.
    drive(1'b1, 32'h414, 5'd9, 5'd9, 32'hF1, 32'hF2, 32'h0, 5'd12, 1'b1, 1'b1, 1'b1);
    cyc("F_nonload_ready", 1'b1);
    chk("F_ex_pc", ex_pc, 32'h414);
    // F is a load to r12; G reads r12 through rt.
    drive(1'b1, 32'h418, 5'd0, 5'd12, 32'h71, 32'h72, 32'h5, 5'd13, 1'b1, 1'b0, 1'b1);
    cyc("G_rt_hazard_ready", 1'b0);
    exp_stall++;
    chk("G_bubble_valid", ex_valid, 1'b0);
    cyc("G_issue_ready", 1'b1);
    chk("G_ex_pc", ex_pc, 32'h418);

    // Back-pressure for three cycles.
    drive(1'b1, 32'h41C, 5'd1, 5'd1, 32'h81, 32'h82, 32'h0, 5'd13, 1'b1, 1'b1, 1'b1);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc("hold_ready", 1'b0);
      exp_stall++;
      chk("hold_ex_valid", ex_valid, 1'b1);
      chk("hold_ex_pc", ex_pc, 32'h418);
      chk("hold_ex_rdata1", ex_rdata1, 32'h71);
      chk("hold_ex_wreg", ex_wreg, 5'd13);
    end
    chk_stall("hold_stall");
    ex_ready = 1'b1;
    cyc("hold_release_ready", 1'b1);
    chk("H_ex_pc", ex_pc, 32'h41C);
    chk("H_ex_mem_read", ex_mem_read, 1'b1);

    // Flush with a simultaneous load-use hazard and back-pressure: H is discarded.
    drive(1'b1, 32'h420, 5'd13, 5'd0, 32'h1, 32'h2, 32'h3, 5'd1, 1'b1, 1'b0, 1'b0);
    ex_ready = 1'b0;
    flush = 1'b1;
    void'(exp_q.pop_front());
    cyc("flush_ready", 1'b1);
    chk("flush_ex_valid", ex_valid, 1'b0);
    chk("flush_ex_rw", ex_reg_write, 1'b0);
    chk("flush_ex_mr", ex_mem_read, 1'b0);
    chk_stall("flush_stall");
    flush = 1'b0;
    ex_ready = 1'b1;
    drive(1'b1, 32'h424, 5'd13, 5'd13, 32'h91, 32'h92, 32'h7, 5'd14, 1'b0, 1'b0, 1'b1);
    cyc("post_flush_ready", 1'b1);
    chk("J_ex_valid", ex_valid, 1'b1);
    chk("J_ex_pc", ex_pc, 32'h424);

    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc("idle_ready", 1'b1);
    chk("idle_ex_valid", ex_valid, 1'b0);
    chk("idle_ex_rw", ex_reg_write, 1'b0);

    // Enter BUBBLE, then reset between edges.
    drive(1'b1, 32'h428, 5'd2, 5'd3, 32'hA1, 32'hA2, 32'h0, 5'd14, 1'b1, 1'b1, 1'b1);
    cyc("K_ready", 1'b1);
    chk("K_ex_pc", ex_pc, 32'h428);
    drive(1'b1, 32'h42C, 5'd14, 5'd0, 32'h1, 32'h2, 32'h3, 5'd1, 1'b1, 1'b0, 1'b0);
    cyc("L_hazard_ready", 1'b0);
    exp_stall++;
    chk("L_bubble_valid", ex_valid, 1'b0);
    chk_stall("L_stall");
    #2;
    reset = 1'b0;
    #1;
    exp_stall = 0;
    chk("arst_ex_valid", ex_valid, 1'b0);
    chk("arst_ex_pc", ex_pc, 32'h0);
    chk("arst_ex_rdata1", ex_rdata1, 32'h0);
    chk("arst_ex_rdata2", ex_rdata2, 32'h0);
    chk("arst_ex_imm", ex_imm, 32'h0);
    chk("arst_ex_wreg", ex_wreg, 5'd0);
    chk("arst_ex_mr", ex_mem_read, 1'b0);
    chk_stall("arst_stall");
    drive(1'b1, 32'h500, 5'd14, 5'd14, 32'h51, 32'h52, 32'h53, 5'd15, 1'b1, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    chk("M_ready", id_ready, 1'b1);
    @(posedge clock);
    #1;
    chk("M_ex_valid", ex_valid, 1'b1);
    chk("M_ex_pc", ex_pc, 32'h500);

    drive(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    cyc("end_ready", 1'b1);
    chk("end_ex_valid", ex_valid, 1'b0);
    @(posedge clock);
    #1;
    chk("queue_drained", exp_q.size(), 32'd0);
    chk_stall("end_stall");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 The block SHALL expose `clock` (input, 1): the single clock; every register updates on its rising edge.
REQ-002 The block SHALL expose `reset` (input, 1): asynchronous, active-low reset; `reset`=0 clears all state immediately, independent of `clock`.
REQ-003 The block SHALL expose `id_valid` (input, 1): the decode stage presents a valid instruction.
REQ-004 The block SHALL expose `id_ready` (output, 1): this block accepts the decode instruction this cycle.
REQ-005 The block SHALL expose `id_pc` (input, 32): PC of the decode instruction.
REQ-006 The block SHALL expose `id_rs` and `id_rt` (inputs, 5 each): source register numbers.
REQ-007 The block SHALL expose `id_rdata1` and `id_rdata2` (inputs, 32 each): register-file read data for rs and rt.
REQ-008 The block SHALL expose `id_imm` (input, 32): sign/zero-extended immediate.
REQ-009 The block SHALL expose `id_wreg` (input, 5): destination register number.
REQ-010 The block SHALL expose `id_reg_write` and `id_mem_read` (inputs, 1 each): destination-write flag and load flag.
REQ-011 The block SHALL expose `flush` (input, 1): taken branch or jump; squash the decode slot and the execute slot.
REQ-012 The block SHALL expose `ex_ready` (input, 1): the execute stage can accept new work.
REQ-013 The block SHALL expose `ex_valid` (output, 1): the execute slot holds a real instruction.
REQ-014 The block SHALL expose `ex_pc`, `ex_rdata1`, `ex_rdata2`, `ex_imm` (outputs, 32 each), `ex_wreg` (output, 5), and `ex_reg_write`, `ex_mem_read` (outputs, 1 each): registered copies of the corresponding `id_*` inputs.
REQ-015 The block SHALL expose `stall_cnt` (output, 32): count of bubble cycles; present only when STALL_CNT_EN is defined.

Function
REQ-016 `hazard` SHALL equal `ex_valid & ex_mem_read & (ex_wreg!=0) & id_valid & (ex_wreg==id_rs | ex_wreg==id_rt)`.
REQ-017 `hold` SHALL equal `ex_valid & ~ex_ready`.
REQ-018 `id_ready` SHALL be combinational: 1 if `flush`; otherwise `~hold & ~hazard`.
REQ-019 Each rising edge SHALL resolve by priority flush > hold > hazard > load > idle, with no other priority ordering.
REQ-020 Flush SHALL clear `ex_valid`, `ex_reg_write`, and `ex_mem_read` to 0 and drop the decode instruction.
REQ-021 Hold SHALL keep every `ex_*` register unchanged.
REQ-022 Hazard SHALL insert a bubble: `ex_valid`, `ex_reg_write`, and `ex_mem_read` go to 0, and the decode instruction stays upstream.
REQ-023 Load SHALL apply when `id_valid & id_ready`: capture all `id_*` inputs into `ex_*` and set `ex_valid`=1.
REQ-024 Idle SHALL apply when `~id_valid` with no hold: set `ex_valid`=0.
REQ-025 `ex_reg_write` and `ex_mem_read` SHALL always be forced to 0 whenever `ex_valid`=0.
REQ-026 The state machine SHALL have states RUN and BUBBLE, with the following transitions:
- RUN -> BUBBLE on hazard.
- BUBBLE -> RUN unconditionally after one cycle.
- Flush forces RUN.
REQ-027 In BUBBLE, `hazard` SHALL be 0 by construction because the execute slot is empty.
REQ-028 A load-use dependency SHALL therefore cost exactly one bubble cycle.
REQ-029 Latency SHALL be one cycle from acceptance (`id_valid & id_ready` at edge N) to `ex_valid`=1 after edge N.
REQ-030 A hazard on register $0 SHALL never stall.
REQ-031 When `flush` and `hazard` occur together, flush SHALL win, with no bubble counted and the state set to RUN.
REQ-032 When `flush` and `hold` occur together, flush SHALL win, and the execute slot is cleared even though `ex_ready`=0.

Reset
REQ-033 On `reset`=0 the block SHALL force the following values:
- `ex_valid`, `ex_reg_write`, `ex_mem_read` = 0.
- All `ex_*` data = 0.
- State = RUN.
- `stall_cnt` = 0.
REQ-034 Reset asserted mid-hold or mid-bubble SHALL abandon the held or pending instruction, with no output glitch beyond the clear.
REQ-035 The first rising edge after `reset` returns to 1 SHALL process normally.

Configuration
REQ-036 Defining STALL_CNT_EN SHALL add the `stall_cnt` output.
REQ-037 With STALL_CNT_EN defined, `stall_cnt` SHALL increment by 1 on each edge where a hazard bubble or hold occurs without flush, and SHALL wrap from 0xFFFFFFFF to 0.
REQ-038 Without STALL_CNT_EN, the `stall_cnt` port and its logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-039 Pass-through: feed pc=0x00400000, rdata1=0x11, rdata2=0x22, wreg=8, reg_write=1 -> next cycle `ex_valid`=1, `ex_pc`=0x00400000, `ex_rdata1`=0x11, `ex_wreg`=8, `id_ready`=1 throughout.
REQ-040 Load-use: EX holds a load with wreg=9; ID presents rs=9 -> `id_ready`=0 for one cycle, then one bubble (`ex_valid`=0), then the instruction issues; `stall_cnt` +1.
REQ-041 $0 and non-load cases: EX load with wreg=0 and ID rs=0 -> no stall; EX non-load with wreg=9 and ID rs=9 -> no stall.
REQ-042 Hold: `ex_ready`=0 for 3 cycles -> `ex_*` stable, `id_ready`=0, `stall_cnt` +3; `ex_ready`=1 -> the next instruction loads.
REQ-043 Flush priority: `flush`=1 together with a hazard and with `ex_ready`=0 -> `ex_valid`=0 next cycle, state RUN, `stall_cnt` unchanged.
REQ-044 Async reset: drop `reset` between clock edges during BUBBLE -> outputs clear immediately; after release, the first valid instruction has 1-cycle latency.
